// File: rtl/framebuffer_engine.sv
// rtl/framebuffer_engine.sv - scaled framebuffer with host access and full-screen fill
//
// Purpose: holds RES_W x RES_H pixels of COLOR_DEPTH bits. It feeds a registered
// colour stream to the DAC from the scan position, serves single-pixel host
// writes and reads, and runs a one-entry-per-cycle clear of the whole frame.
//
// Ports:
//   pixel_clock_i      sole clock, rising edge
//   reset_i            asynchronous active-high reset
//   px_i, py_i         scan position from the timing generator (10 bits each)
//   on_screen_i        high inside the visible area
//   color_out_o        registered pixel colour; blanked to 0 off-frame
//   x_pos_i, y_pos_i   host pixel coordinate (8 bits each)
//   color_i            host write colour, also the fill colour
//   write_i, read_i    single-cycle host strobes
//   rdata_o, rvalid_o  read-back data and its one-cycle qualifier
//   clear_i            starts a full-screen fill
//   busy_o             high while the fill runs
module framebuffer_engine #(
  parameter int RES_W       = 160,
  parameter int RES_H       = 120,
  parameter int COLOR_DEPTH = 3,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                   pixel_clock_i,
  input  logic                   reset_i,
  input  logic [9:0]             px_i,
  input  logic [9:0]             py_i,
  input  logic                   on_screen_i,
  output logic [COLOR_DEPTH-1:0] color_out_o,
  input  logic [7:0]             x_pos_i,
  input  logic [7:0]             y_pos_i,
  input  logic [COLOR_DEPTH-1:0] color_i,
  input  logic                   write_i,
  input  logic                   read_i,
  output logic [COLOR_DEPTH-1:0] rdata_o,
  output logic                   rvalid_o,
  input  logic                   clear_i,
  output logic                   busy_o
);

  localparam int NPIX   = RES_W * RES_H;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] RES_W_A   = ADDR_W'(RES_W);
  localparam logic [9:0]        RES_W_10  = 10'(RES_W);
  localparam logic [9:0]        RES_H_10  = 10'(RES_H);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                 state_q;
  logic [ADDR_W-1:0]      fill_addr_q;
  logic [COLOR_DEPTH-1:0] fill_color_q;
  logic                   busy_q;
  logic                   rvalid_q;
  logic [COLOR_DEPTH-1:0] rdata_q;
  logic [COLOR_DEPTH-1:0] color_out_q;

  // Pixel storage; deliberately never reset so a fill interrupted by reset
  // leaves its partial result in place.
  logic [COLOR_DEPTH-1:0] mem [NPIX];

  logic [9:0]             disp_x;
  logic [9:0]             disp_y;
  logic                   disp_ok;
  logic [ADDR_W-1:0]      disp_addr;
  logic                   host_ok;
  logic [ADDR_W-1:0]      host_addr;
  logic                   host_wr;
  logic                   host_rd;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_waddr;
  logic [COLOR_DEPTH-1:0] mem_wdata;

  always_comb begin
    disp_x  = px_i >> SCALE_SHIFT;
    disp_y  = py_i >> SCALE_SHIFT;
    disp_ok = on_screen_i && (disp_x < RES_W_10) && (disp_y < RES_H_10);
    // Address arithmetic may alias when out of range; every use is gated by *_ok.
    disp_addr = ADDR_W'(disp_y) * RES_W_A + ADDR_W'(disp_x);

    host_ok   = ({2'b00, x_pos_i} < RES_W_10) && ({2'b00, y_pos_i} < RES_H_10);
    host_addr = ADDR_W'(y_pos_i) * RES_W_A + ADDR_W'(x_pos_i);

    // Host strobes only count in IDLE, and a simultaneous clear drops them.
    host_wr = (state_q == IDLE) && write_i && !clear_i && host_ok;
    host_rd = (state_q == IDLE) && read_i && !clear_i;

    mem_we    = (state_q == FILL) || host_wr;
    mem_waddr = (state_q == FILL) ? fill_addr_q  : host_addr;
    mem_wdata = (state_q == FILL) ? fill_color_q : color_i;
  end

  // Single write port; reads in the block below see the pre-write contents,
  // which gives read-before-write for a same-cycle host write and read.
  always_ff @(posedge pixel_clock_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge pixel_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      fill_addr_q  <= '0;
      fill_color_q <= '0;
      busy_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      color_out_q  <= '0;
    end else begin
      color_out_q <= disp_ok ? mem[disp_addr] : '0;

      rvalid_q <= host_rd;
      if (host_rd) begin
        rdata_q <= host_ok ? mem[host_addr] : '0;
      end

      case (state_q)
        IDLE: begin
          if (clear_i) begin
            state_q      <= FILL;
            fill_addr_q  <= '0;
            fill_color_q <= color_i;
            busy_q       <= 1'b1;
          end
        end
        FILL: begin
          if (fill_addr_q == LAST_ADDR) begin
            // Counter parks on the last entry; the next clear reloads it.
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            fill_addr_q <= fill_addr_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign color_out_o = color_out_q;
  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_framebuffer_engine.sv
// tb/tb_framebuffer_engine.sv - directed vector bench for framebuffer_engine
module tb_framebuffer_engine;

  localparam int NPIX = 160 * 120;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] px, py;
  logic       on_screen;
  logic [2:0] color_out;
  logic [7:0] x_pos, y_pos;
  logic [2:0] color;
  logic       wr, rd, clr;
  logic [2:0] rdata;
  logic       rvalid;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  framebuffer_engine #(
    .RES_W(160), .RES_H(120), .COLOR_DEPTH(3), .SCALE_SHIFT(2)
  ) dut (
    .pixel_clock_i(clk),
    .reset_i      (rst),
    .px_i         (px),
    .py_i         (py),
    .on_screen_i  (on_screen),
    .color_out_o  (color_out),
    .x_pos_i      (x_pos),
    .y_pos_i      (y_pos),
    .color_i      (color),
    .write_i      (wr),
    .read_i       (rd),
    .rdata_o      (rdata),
    .rvalid_o     (rvalid),
    .clear_i      (clr),
    .busy_o       (busy)
  );

  typedef struct packed {
    logic       wr, rd, clr;
    logic [7:0] x, y;
    logic [2:0] col;
    logic [9:0] px, py;
    logic       on;
    logic       exp_rv;
    logic [2:0] exp_rd;
    logic [2:0] exp_co;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [7:0] x, input logic [7:0] y,
                         input logic [2:0] exp);
    x_pos = x; y_pos = y; rd = 1'b1;
    tick();
    rd = 1'b0;
    check({name, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check({name, "_rdata"}, {29'd0, rdata}, {29'd0, exp});
  endtask

  // Counts cycles with busy high, starting from the sample after the clear edge.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 25000) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    int cnt;
    logic rv_seen;

    // wr rd clr   x      y     col      px      py    on  rv  rdata   cout
    vecs[0]  = '{1,0,0, 8'd10, 8'd10, 3'b001, 10'd0,   10'd0,   1, 0, 3'b000, 3'b000};
    vecs[1]  = '{0,1,0, 8'd10, 8'd10, 3'b000, 10'd40,  10'd40,  1, 1, 3'b001, 3'b001};
    vecs[2]  = '{0,0,0, 8'd0,  8'd0,  3'b000, 10'd43,  10'd43,  1, 0, 3'b001, 3'b001};
    vecs[3]  = '{0,0,0, 8'd0,  8'd0,  3'b000, 10'd44,  10'd40,  1, 0, 3'b001, 3'b000};
    vecs[4]  = '{0,0,0, 8'd0,  8'd0,  3'b000, 10'd40,  10'd40,  0, 0, 3'b001, 3'b000};
    vecs[5]  = '{1,0,0, 8'd160,8'd5,  3'b111, 10'd640, 10'd40,  1, 0, 3'b001, 3'b000};
    vecs[6]  = '{1,1,0, 8'd5,  8'd120,3'b111, 10'd40,  10'd40,  1, 0, 3'b001, 3'b001};
    vecs[7]  = '{0,1,0, 8'd0,  8'd6,  3'b000, 10'd0,   10'd0,   0, 1, 3'b000, 3'b000};
    vecs[8]  = '{1,0,0, 8'd40, 8'd1,  3'b110, 10'd0,   10'd0,   0, 0, 3'b000, 3'b000};
    vecs[9]  = '{0,1,0, 8'd10, 8'd10, 3'b000, 10'd0,   10'd0,   0, 1, 3'b001, 3'b000};
    vecs[10] = '{0,1,0, 8'd200,8'd0,  3'b000, 10'd0,   10'd0,   0, 1, 3'b000, 3'b000};
    vecs[11] = '{1,0,0, 8'd20, 8'd20, 3'b010, 10'd0,   10'd0,   0, 0, 3'b000, 3'b000};
    vecs[12] = '{1,1,0, 8'd20, 8'd20, 3'b101, 10'd0,   10'd0,   0, 1, 3'b010, 3'b000};
    vecs[13] = '{0,1,0, 8'd20, 8'd20, 3'b000, 10'd80,  10'd83,  1, 1, 3'b101, 3'b101};
    vecs[14] = '{1,0,0, 8'd159,8'd119,3'b011, 10'd639, 10'd479, 0, 0, 3'b101, 3'b000};
    vecs[15] = '{0,0,0, 8'd0,  8'd0,  3'b000, 10'd639, 10'd479, 1, 0, 3'b101, 3'b011};
    // Row 6 also reads (5,120): out of range, so rdata 0 with rvalid... but the
    // write in row 6 targets (5,120) and the read of that row is out of range too.
    vecs[6].exp_rv = 1'b1;
    vecs[6].exp_rd = 3'b000;

    rst = 1'b1; px = '0; py = '0; on_screen = 1'b0;
    x_pos = '0; y_pos = '0; color = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_cout", {29'd0, color_out}, 32'd0);
    check("reset_rdata", {29'd0, rdata}, 32'd0);
    check("reset_rvalid", {31'd0, rvalid}, 32'd0);
    rst = 1'b0;

    // Zero the frame so the table starts from known contents.
    clr = 1'b1; color = 3'b000;
    tick();
    clr = 1'b0;
    count_busy(cnt);
    check("init_fill_cycles", cnt, NPIX);

    for (int i = 0; i < 16; i++) begin
      wr = vecs[i].wr; rd = vecs[i].rd; clr = vecs[i].clr;
      x_pos = vecs[i].x; y_pos = vecs[i].y; color = vecs[i].col;
      px = vecs[i].px; py = vecs[i].py; on_screen = vecs[i].on;
      tick();
      check($sformatf("vec%0d_rvalid", i), {31'd0, rvalid}, {31'd0, vecs[i].exp_rv});
      check($sformatf("vec%0d_rdata", i), {29'd0, rdata}, {29'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_cout", i), {29'd0, color_out}, {29'd0, vecs[i].exp_co});
    end
    idle_inputs();
    on_screen = 1'b0;

    // CLEAR with WRITE and READ in the same cycle: clear wins.
    clr = 1'b1; wr = 1'b1; rd = 1'b1; color = 3'b100; x_pos = 8'd20; y_pos = 8'd20;
    tick();
    idle_inputs();
    check("clear_busy_next", {31'd0, busy}, 32'd1);
    check("clear_drops_read", {31'd0, rvalid}, 32'd0);
    cnt = 0; rv_seen = 1'b0;
    while (busy && cnt < 25000) begin
      cnt++;
      if (cnt == 100 || cnt == 10000) begin
        wr = 1'b1; rd = 1'b1; clr = 1'b1; color = 3'b010; x_pos = 8'd0; y_pos = 8'd0;
      end else begin
        idle_inputs();
      end
      tick();
      if (rvalid) rv_seen = 1'b1;
    end
    idle_inputs();
    check("fill_cycles", cnt, NPIX);
    check("no_rvalid_in_fill", {31'd0, rv_seen}, 32'd0);
    do_read("fill_0_0", 8'd0, 8'd0, 3'b100);
    do_read("fill_159_119", 8'd159, 8'd119, 3'b100);
    do_read("fill_20_20", 8'd20, 8'd20, 3'b100);

    // Reset in the middle of a fill, with fill address at 5000.
    px = 10'd0; py = 10'd0; on_screen = 1'b1;
    clr = 1'b1; color = 3'b010;
    tick();
    clr = 1'b0;
    repeat (5000) @(posedge clk);
    #1;
    check("prereset_cout", {29'd0, color_out}, 32'd2);
    rst = 1'b1;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_cout", {29'd0, color_out}, 32'd0);
    check("async_rdata", {29'd0, rdata}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    on_screen = 1'b0;
    do_read("post_reset_0_0", 8'd0, 8'd0, 3'b010);
    check("no_resume", {31'd0, busy}, 32'd0);
    do_read("addr4999", 8'd39, 8'd31, 3'b010);
    do_read("addr5000", 8'd40, 8'd31, 3'b100);

    clr = 1'b1; color = 3'b001;
    tick();
    clr = 1'b0;
    count_busy(cnt);
    check("refill_cycles", cnt, NPIX);
    do_read("refill_addr5000", 8'd40, 8'd31, 3'b001);
    do_read("refill_last", 8'd159, 8'd119, 3'b001);
    px = 10'd636; py = 10'd476; on_screen = 1'b1;
    tick();
    check("refill_display", {29'd0, color_out}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/framebuffer_engine.md
FRAMEBUFFER_ENGINE -- requirements
Module: framebuffer_engine

Interface
REQ-001 SHALL have parameter RES_W, default 160, logical width in pixels.
REQ-002 SHALL have parameter RES_H, default 120, logical height in pixels.
REQ-003 SHALL have parameter COLOR_DEPTH, default 3, bits per pixel.
REQ-004 SHALL have parameter SCALE_SHIFT, default 2, display pixel replication factor of 2^SCALE_SHIFT in each axis.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, as below.
REQ-006 PIXEL_CLOCK  in  1  sole clock; all state updates on its rising edge.
REQ-007 RESET  in  1  asynchronous, active-high reset.
REQ-008 PX, PY  in  10 each  current scan position from the timing generator.
REQ-009 ON_SCREEN  in  1  high inside the visible area.
REQ-010 COLOR_OUT  out  COLOR_DEPTH  registered pixel colour to the DAC; bit0=R, bit1=G, bit2=B when COLOR_DEPTH=3.
REQ-011 X_POS, Y_POS  in  8 each  host pixel coordinate.
REQ-012 COLOR  in  COLOR_DEPTH  host write colour, also the clear colour.
REQ-013 WRITE  in  1  single-cycle write strobe.
REQ-014 READ  in  1  single-cycle read-back strobe.
REQ-015 RDATA  out  COLOR_DEPTH  read-back data.
REQ-016 RVALID  out  1  one-cycle pulse qualifying RDATA.
REQ-017 CLEAR  in  1  strobe starting a full-screen fill.
REQ-018 BUSY  out  1  high while a fill is running.

Function
REQ-019 Storage SHALL be RES_W*RES_H entries of COLOR_DEPTH bits, linear address = Y*RES_W + X.
REQ-020 Display coordinates SHALL be x = PX >> SCALE_SHIFT, y = PY >> SCALE_SHIFT.
REQ-021 COLOR_OUT SHALL equal the stored pixel one cycle after PX/PY are presented when ON_SCREEN=1 and x<RES_W and y<RES_H; otherwise 0 (blanked, not held).
REQ-022 In IDLE, WRITE with X_POS<RES_W and Y_POS<RES_H SHALL store COLOR; display of that pixel reflects it from the next cycle.
REQ-023 Out-of-range WRITE or READ SHALL not modify storage; an out-of-range READ SHALL still pulse RVALID with RDATA=0.
REQ-024 In IDLE, READ SHALL produce RDATA with RVALID=1 exactly one cycle later; RDATA holds until the next RVALID.
REQ-025 Simultaneous WRITE and READ of the same pixel SHALL return the old value (read-before-write).
REQ-026 State machine SHALL have states IDLE and FILL.
REQ-027 IDLE->FILL on CLEAR=1: latch COLOR as fill colour, fill address <=0, BUSY=1 from the next cycle.
REQ-028 FILL SHALL write one entry per cycle at addresses 0..RES_W*RES_H-1 in order, total RES_W*RES_H cycles.
REQ-029 FILL->IDLE after writing the last address; BUSY=0 in the cycle after the final write.
REQ-030 CLEAR, WRITE and READ asserted while BUSY=1 SHALL be ignored (no RVALID, no storage change, no restart).
REQ-031 CLEAR together with WRITE and/or READ in IDLE: CLEAR wins; WRITE and READ dropped.
REQ-032 Display reads SHALL continue during FILL, showing a mix of old and fill colour.
REQ-033 Fill address counter SHALL be sized ceil(log2(RES_W*RES_H)) bits and never wrap past the last entry.

Reset
REQ-034 RESET SHALL immediately force IDLE, BUSY=0, COLOR_OUT=0, RDATA=0, RVALID=0, fill address 0.
REQ-035 Storage contents SHALL not be initialised by RESET; reset mid-FILL leaves partially filled contents and SHALL not resume.
REQ-036 First cycle after RESET deassertion SHALL accept WRITE, READ and CLEAR normally.

Verification
REQ-037 WRITE X=10,Y=10,COLOR=3'b001; READ same -> RVALID one cycle later, RDATA=3'b001; PX=40..43,PY=40..43 with ON_SCREEN -> COLOR_OUT=3'b001 next cycle.
REQ-038 CLEAR with COLOR=3'b100 -> BUSY high 19200 cycles; WRITE/READ/CLEAR during fill ignored; afterwards READ at (0,0) and (159,119) -> 3'b100.
REQ-039 WRITE X=160,Y=5 and X=5,Y=120 -> no storage change; READ X=200 -> RVALID, RDATA=0.
REQ-040 PX=640 (x=160) or ON_SCREEN=0 -> COLOR_OUT=0 next cycle regardless of storage.
REQ-041 RESET asserted at fill address 5000 -> BUSY=0 and outputs 0 asynchronously; addresses <5000 hold fill colour; new CLEAR restarts at 0.
REQ-042 Same-cycle CLEAR+WRITE in IDLE -> fill starts, written pixel ends with fill colour; same-cycle WRITE+READ at (20,20) -> RDATA old value.
